// File: rtl/mem_arb_pkg.sv
// Shared types and width helpers for the memory request arbiter.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BUSY    = 2'd1,
        RELEASE = 2'd2
    } arb_state_e;

    localparam int DEF_NUM_CORES      = 2;
    localparam int DEF_ADDR_W         = 20;
    localparam int DEF_DATA_W         = 128;
    localparam int DEF_TIMEOUT_CYCLES = 1024;

    // grant_id keeps at least one bit so a single-core build still has a port.
    function automatic int grant_width(input int num_cores);
        return (num_cores <= 1) ? 1 : $clog2(num_cores);
    endfunction

    function automatic int wdog_width(input int timeout_cycles);
        return $clog2(timeout_cycles + 1);
    endfunction

endpackage

// File: rtl/mem_req_arbiter_if.sv
// Core-side and SRAM-line-side bus of the arbiter; slave is the arbiter's view.
interface mem_req_arbiter_if #(
    parameter int NUM_CORES = 2,
    parameter int ADDR_W    = 20,
    parameter int DATA_W    = 128
);
    logic [NUM_CORES-1:0]        core_req;
    logic [NUM_CORES-1:0]        core_we;
    logic [NUM_CORES*ADDR_W-1:0] core_addr;
    logic [NUM_CORES*DATA_W-1:0] core_wdata;
    logic [NUM_CORES-1:0]        core_ready;
    logic [DATA_W-1:0]           core_rdata;

    logic                        mem_req;
    logic                        mem_we;
    logic [ADDR_W-1:0]           mem_addr;
    logic [DATA_W-1:0]           mem_wdata;
    logic                        mem_req_reset;
    logic                        mem_ready;
    logic [DATA_W-1:0]           mem_rdata;

    modport master (
        output core_req, core_we, core_addr, core_wdata, mem_ready, mem_rdata,
        input  core_ready, core_rdata, mem_req, mem_we, mem_addr, mem_wdata, mem_req_reset
    );

    modport slave (
        input  core_req, core_we, core_addr, core_wdata, mem_ready, mem_rdata,
        output core_ready, core_rdata, mem_req, mem_we, mem_addr, mem_wdata, mem_req_reset
    );
endinterface

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first requester strictly after last_grant_i, with wrap.
module rr_pick #(
    parameter int NUM_CORES = 2,
    parameter int GRANT_W   = 1
) (
    input  logic [NUM_CORES-1:0] req_i,
    input  logic [GRANT_W-1:0]   last_grant_i,
    output logic [GRANT_W-1:0]   winner_o,
    output logic                 valid_o
);
    localparam int SUM_W = GRANT_W + 1;
    localparam logic [SUM_W-1:0] N_L = SUM_W'(NUM_CORES);

    logic [2*NUM_CORES-1:0] dbl_sh;
    logic [NUM_CORES-1:0]   rot;
    logic [SUM_W-1:0]       offset;
    logic [SUM_W-1:0]       sum;

    // Rotating a doubled copy puts the core after last_grant at bit 0.
    assign dbl_sh = {req_i, req_i} >> ({1'b0, last_grant_i} + SUM_W'(1));
    assign rot    = dbl_sh[NUM_CORES-1:0];

    // NOTE: every output of a combinational block gets a default first, so no path can infer a latch.
    always_comb begin
        offset  = '0;
        valid_o = 1'b0;
        for (int i = NUM_CORES - 1; i >= 0; i--) begin
            if (rot[i]) begin
                offset  = SUM_W'(i);
                valid_o = 1'b1;
            end
        end
        sum = {1'b0, last_grant_i} + SUM_W'(1) + offset;
        if (sum >= N_L) begin
            sum = sum - N_L;
        end
        winner_o = sum[GRANT_W-1:0];
    end
endmodule

// File: rtl/mem_req_arbiter.sv
// Round-robin arbiter sharing the SRAM line port among cores, with grant hold-off and a watchdog.
module mem_req_arbiter
    import mem_arb_pkg::*;
#(
    parameter int NUM_CORES      = DEF_NUM_CORES,
    parameter int ADDR_W         = DEF_ADDR_W,
    parameter int DATA_W         = DEF_DATA_W,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
    localparam int GRANT_W       = grant_width(NUM_CORES),
    localparam int WDOG_W        = wdog_width(TIMEOUT_CYCLES)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 hold_grants_i,
    mem_req_arbiter_if.slave     bus,
    output logic                 err_timeout_o,
    output logic [GRANT_W-1:0]   grant_id_o
);
    arb_state_e           state_q;
    logic [GRANT_W-1:0]   grant_q, last_grant_q;
    logic [WDOG_W-1:0]    wdog_q, wdog_d;
    logic                 mem_req_q, mem_we_q, mem_req_reset_q, err_q;
    logic [ADDR_W-1:0]    mem_addr_q;
    logic [DATA_W-1:0]    mem_wdata_q, core_rdata_q;
    logic [NUM_CORES-1:0] core_ready_q;

    logic [GRANT_W-1:0]   winner;
    logic                 winner_valid;
    logic                 sel_we, granted_req, timeout_hit;
    logic [ADDR_W-1:0]    sel_addr;
    logic [DATA_W-1:0]    sel_wdata;

    rr_pick #(
        .NUM_CORES (NUM_CORES),
        .GRANT_W   (GRANT_W)
    ) u_pick (
        .req_i        (bus.core_req),
        .last_grant_i (last_grant_q),
        .winner_o     (winner),
        .valid_o      (winner_valid)
    );

    // Fields of the picked core feed the latches; granted_req tracks the current grantee.
    always_comb begin
        sel_we      = 1'b0;
        sel_addr    = '0;
        sel_wdata   = '0;
        granted_req = 1'b0;
        for (int i = 0; i < NUM_CORES; i++) begin
            if (winner == GRANT_W'(i)) begin
                sel_we    = bus.core_we[i];
                sel_addr  = bus.core_addr[i*ADDR_W +: ADDR_W];
                sel_wdata = bus.core_wdata[i*DATA_W +: DATA_W];
            end
            if (grant_q == GRANT_W'(i)) begin
                granted_req = bus.core_req[i];
            end
        end
    end

    assign wdog_d      = wdog_q + WDOG_W'(1);
    assign timeout_hit = (wdog_d == WDOG_W'(TIMEOUT_CYCLES));

    // NOTE: the datapath latches are reset along with the control state because every output must read 0 in reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q         <= IDLE;
            grant_q         <= '0;
            last_grant_q    <= GRANT_W'(NUM_CORES - 1);
            wdog_q          <= '0;
            mem_req_q       <= 1'b0;
            mem_we_q        <= 1'b0;
            mem_addr_q      <= '0;
            mem_wdata_q     <= '0;
            mem_req_reset_q <= 1'b0;
            core_ready_q    <= '0;
            core_rdata_q    <= '0;
            err_q           <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments keep every register reading its pre-edge value.
            core_ready_q    <= '0;
            mem_req_reset_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (!hold_grants_i && winner_valid) begin
                        grant_q     <= winner;
                        mem_we_q    <= sel_we;
                        mem_addr_q  <= sel_addr;
                        mem_wdata_q <= sel_wdata;
                        mem_req_q   <= 1'b1;
                        wdog_q      <= '0;
                        state_q     <= BUSY;
                    end
                end
                BUSY: begin
                    wdog_q <= wdog_d;
                    if (bus.mem_ready) begin
                        core_rdata_q    <= bus.mem_rdata;
                        core_ready_q    <= NUM_CORES'(1) << grant_q;
                        mem_req_q       <= 1'b0;
                        mem_req_reset_q <= 1'b1;
                        state_q         <= RELEASE;
                    end else if (timeout_hit) begin
                        err_q           <= 1'b1;
                        core_rdata_q    <= '0;
                        core_ready_q    <= NUM_CORES'(1) << grant_q;
                        mem_req_q       <= 1'b0;
                        mem_req_reset_q <= 1'b1;
                        state_q         <= RELEASE;
                    end
                end
                RELEASE: begin
                    if (!granted_req) begin
                        last_grant_q <= grant_q;
                        state_q      <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.mem_req       = mem_req_q;
    assign bus.mem_we        = mem_we_q;
    assign bus.mem_addr      = mem_addr_q;
    assign bus.mem_wdata     = mem_wdata_q;
    assign bus.mem_req_reset = mem_req_reset_q;
    assign bus.core_ready    = core_ready_q;
    assign bus.core_rdata    = core_rdata_q;
    assign err_timeout_o     = err_q;
    assign grant_id_o        = grant_q;
endmodule
